// File: rtl/pipeline_exec_controller.sv
// Execution sequencer for the 5-stage MIPS pipeline: run, single-step, stall, flush and halt-drain.
// Optional RUN cycle limit enabled by defining CYCLE_LIMIT_EN.
module pipeline_exec_controller #(
    parameter int unsigned NB_CYCLE_CNT = 32,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter logic [31:0] MAX_CYCLES   = 32'hFFFF_FFFF
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_run,
    input  logic                    i_step,
    input  logic                    i_clear,
    input  logic                    i_halt_detect,
    input  logic                    i_load_use_hazard,
    input  logic                    i_branch_taken,
    output logic                    o_pc_enable,
    output logic                    o_if_id_enable,
    output logic                    o_if_id_flush,
    output logic                    o_pipe_enable,
    output logic [2:0]              o_state,
    output logic [NB_CYCLE_CNT-1:0] o_cycle_count,
    output logic                    o_done,
    output logic                    o_timeout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        STEP  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int unsigned           DRN_W      = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRN_W-1:0]      DRAIN_LOAD = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic [NB_CYCLE_CNT-1:0] CNT_ONE  = NB_CYCLE_CNT'(1);

    state_t                  state_q, state_d;
    logic [DRN_W-1:0]        drain_q, drain_d;
    logic [NB_CYCLE_CNT-1:0] cnt_q, cnt_d;
    logic                    pc_en, ifid_en, ifid_fl, pipe_en, done;
    logic                    stop_run;

`ifdef CYCLE_LIMIT_EN
    localparam logic [NB_CYCLE_CNT-1:0] CNT_LIMIT = NB_CYCLE_CNT'(MAX_CYCLES - 32'd1);
    logic timeout_q, timeout_d;
    logic limit_hit;
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= IDLE;
            drain_q   <= '0;
            cnt_q     <= '0;
`ifdef CYCLE_LIMIT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            cnt_q     <= cnt_d;
`ifdef CYCLE_LIMIT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        cnt_d   = cnt_q;
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        ifid_fl = 1'b0;
        pipe_en = 1'b0;
        done    = 1'b0;
`ifdef CYCLE_LIMIT_EN
        timeout_d = timeout_q;
        limit_hit = (cnt_q == CNT_LIMIT);
        stop_run  = i_halt_detect | limit_hit;
`else
        stop_run  = i_halt_detect;
`endif

        case (state_q)
            IDLE: begin
                if (i_run) begin
                    state_d = RUN;
                end else if (i_step) begin
                    state_d = STEP;
                end
            end
            RUN, STEP: begin
                // A taken branch overrides the stall: PC must follow the branch target.
                pipe_en = 1'b1;
                ifid_fl = i_branch_taken;
                pc_en   = i_branch_taken | ~i_load_use_hazard;
                ifid_en = ~i_load_use_hazard;
                if (state_q == RUN) begin
                    if (stop_run) begin
                        state_d = DRAIN;
                        drain_d = DRAIN_LOAD;
`ifdef CYCLE_LIMIT_EN
                        if (limit_hit) begin
                            timeout_d = 1'b1;
                        end
`endif
                    end else if (!i_run) begin
                        state_d = IDLE;
                    end
                end else begin
                    if (i_halt_detect) begin
                        state_d = DRAIN;
                        drain_d = DRAIN_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                pipe_en = 1'b1;
                ifid_fl = 1'b1;
                if (drain_q == '0) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q - DRN_W'(1);
                end
            end
            DONE: begin
                done = 1'b1;
                if (i_clear) begin
                    state_d = IDLE;
                    cnt_d   = '0;
`ifdef CYCLE_LIMIT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pipe_en && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    assign o_pc_enable    = pc_en;
    assign o_if_id_enable = ifid_en;
    assign o_if_id_flush  = ifid_fl;
    assign o_pipe_enable  = pipe_en;
    assign o_state        = state_q;
    assign o_cycle_count  = cnt_q;
    assign o_done         = done;
`ifdef CYCLE_LIMIT_EN
    assign o_timeout      = timeout_q;
`else
    assign o_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_exec_controller.sv
// Bench for pipeline_exec_controller: vector table, directed corner sequences and random traffic vs a reference model.
module tb_pipeline_exec_controller;

    localparam int unsigned DRAIN = 4;
    localparam logic [31:0] MAXC  = 32'd8;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_run = 1'b0, i_step = 1'b0, i_clear = 1'b0;
    logic        i_halt_detect = 1'b0, i_load_use_hazard = 1'b0, i_branch_taken = 1'b0;
    logic        o_pc_enable, o_if_id_enable, o_if_id_flush, o_pipe_enable;
    logic [2:0]  o_state;
    logic [31:0] o_cycle_count;
    logic        o_done, o_timeout;

    pipeline_exec_controller #(
        .NB_CYCLE_CNT(32),
        .DRAIN_CYCLES(DRAIN),
        .MAX_CYCLES  (MAXC)
    ) dut (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .i_run            (i_run),
        .i_step           (i_step),
        .i_clear          (i_clear),
        .i_halt_detect    (i_halt_detect),
        .i_load_use_hazard(i_load_use_hazard),
        .i_branch_taken   (i_branch_taken),
        .o_pc_enable      (o_pc_enable),
        .o_if_id_enable   (o_if_id_enable),
        .o_if_id_flush    (o_if_id_flush),
        .o_pipe_enable    (o_pipe_enable),
        .o_state          (o_state),
        .o_cycle_count    (o_cycle_count),
        .o_done           (o_done),
        .o_timeout        (o_timeout)
    );

    always #5 i_clock = ~i_clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: activity mode, remaining drain cycles, executed-cycle total, timeout flag.
    int          m_mode;
    int          m_drain_left;
    logic [31:0] m_cnt;
    logic        m_to;

    task automatic model_reset();
        m_mode = 0; m_drain_left = 0; m_cnt = '0; m_to = 1'b0;
    endtask

    function automatic logic [40:0] model_exp();
        logic pc = 0, ifid = 0, fl = 0, pipe = 0, dn = 0;
        if (m_mode == 1 || m_mode == 2) begin
            pipe = 1; fl = i_branch_taken;
            if (i_branch_taken && i_load_use_hazard) begin
                pc = 1; ifid = 0;
            end else begin
                pc = !i_load_use_hazard; ifid = !i_load_use_hazard;
            end
        end else if (m_mode == 3) begin
            pipe = 1; fl = 1;
        end else if (m_mode == 4) begin
            dn = 1;
        end
        return {3'(m_mode), pc, ifid, fl, pipe, dn, m_to, m_cnt};
    endfunction

    task automatic model_step();
        int  nxt = m_mode;
        bit  counted = (m_mode >= 1 && m_mode <= 3);
        bit  limit = 0;
`ifdef CYCLE_LIMIT_EN
        limit = (m_mode == 1) && (m_cnt == MAXC - 1);
`endif
        case (m_mode)
            0: if (i_run) nxt = 1; else if (i_step) nxt = 2;
            1: begin
                if (i_halt_detect || limit) begin
                    nxt = 3; m_drain_left = DRAIN;
                    if (limit) m_to = 1;
                end else if (!i_run) nxt = 0;
            end
            2: begin
                if (i_halt_detect) begin nxt = 3; m_drain_left = DRAIN; end
                else nxt = 0;
            end
            3: begin
                m_drain_left--;
                if (m_drain_left == 0) nxt = 4;
            end
            default: if (i_clear) begin nxt = 0; m_cnt = '0; m_to = 0; end
        endcase
        if (counted && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        m_mode = nxt;
    endtask

    function automatic logic [40:0] dut_vec();
        return {o_state, o_pc_enable, o_if_id_enable, o_if_id_flush, o_pipe_enable,
                o_done, o_timeout, o_cycle_count};
    endfunction

    task automatic check(input string nm, input logic [40:0] act, input logic [40:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Input order: run, step, clear, halt, hazard, branch
    task automatic drive(input logic [5:0] in);
        {i_run, i_step, i_clear, i_halt_detect, i_load_use_hazard, i_branch_taken} = in;
        #3;
    endtask

    task automatic advance();
        @(posedge i_clock);
        #1;
        model_step();
    endtask

    task automatic cyc(input logic [5:0] in, input string nm);
        drive(in);
        check(nm, dut_vec(), model_exp());
        advance();
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        {i_run, i_step, i_clear, i_halt_detect, i_load_use_hazard, i_branch_taken} = '0;
        model_reset();
        #2;
        check("reset_state", dut_vec(), model_exp());
        @(posedge i_clock);
        #1;
        i_reset = 1'b1;
    endtask

    typedef struct packed {
        logic [5:0]  in;
        logic [2:0]  st;
        logic [4:0]  o;    // pc, if_id, flush, pipe, done
        logic [31:0] cnt;
    } vec_t;

    function automatic vec_t mkv(logic [5:0] in, logic [2:0] st, logic [4:0] o, logic [31:0] c);
        vec_t v;
        v.in = in; v.st = st; v.o = o; v.cnt = c;
        return v;
    endfunction

    vec_t tbl[19];

    initial begin
        tbl[0]  = mkv(6'b100000, 3'd0, 5'b00000, 0);
        tbl[1]  = mkv(6'b100000, 3'd1, 5'b11010, 0);
        tbl[2]  = mkv(6'b100010, 3'd1, 5'b00010, 1);
        tbl[3]  = mkv(6'b100011, 3'd1, 5'b10110, 2);
        tbl[4]  = mkv(6'b100001, 3'd1, 5'b11110, 3);
        tbl[5]  = mkv(6'b001000, 3'd1, 5'b11010, 4);
        tbl[6]  = mkv(6'b000000, 3'd0, 5'b00000, 5);
        tbl[7]  = mkv(6'b110000, 3'd0, 5'b00000, 5);
        tbl[8]  = mkv(6'b100100, 3'd1, 5'b11010, 5);
        tbl[9]  = mkv(6'b110011, 3'd3, 5'b00110, 6);
        tbl[10] = mkv(6'b000000, 3'd3, 5'b00110, 7);
        tbl[11] = mkv(6'b000000, 3'd3, 5'b00110, 8);
        tbl[12] = mkv(6'b000000, 3'd3, 5'b00110, 9);
        tbl[13] = mkv(6'b110000, 3'd4, 5'b00001, 10);
        tbl[14] = mkv(6'b001000, 3'd4, 5'b00001, 10);
        tbl[15] = mkv(6'b000000, 3'd0, 5'b00000, 0);
        tbl[16] = mkv(6'b010000, 3'd0, 5'b00000, 0);
        tbl[17] = mkv(6'b000000, 3'd2, 5'b11010, 0);
        tbl[18] = mkv(6'b000000, 3'd0, 5'b00000, 1);

        model_reset();
        #3;
        check("reset_init", dut_vec(), model_exp());
        @(posedge i_clock);
        #1;
        i_reset = 1'b1;

        for (int unsigned k = 0; k < 19; k++) begin
            drive(tbl[k].in);
            check($sformatf("table_%0d", k),
                  {o_state, o_pc_enable, o_if_id_enable, o_if_id_flush, o_pipe_enable, o_done, o_cycle_count},
                  {tbl[k].st, tbl[k].o, tbl[k].cnt});
            check($sformatf("table_model_%0d", k), dut_vec(), model_exp());
            advance();
        end

        // Asynchronous reset in the middle of RUN
        do_reset();
        for (int k = 0; k < 8; k++) cyc(6'b100000, "run_pre_reset");
        check("pre_reset_count", {9'd0, o_cycle_count}, {9'd0, 32'd7});
        i_run = 1'b0;
        i_reset = 1'b0;
        #1;
        check("async_reset", dut_vec(), 41'd0);
        model_reset();
        @(posedge i_clock);
        #1;
        check("reset_held", dut_vec(), 41'd0);
        i_reset = 1'b1;
        cyc(6'b000000, "idle_after_reset");
        cyc(6'b000000, "idle_after_reset");

        // Run to halt on cycle 10, then drain
        cyc(6'b100000, "halt_idle");
        for (int k = 1; k <= 10; k++) cyc((k == 10) ? 6'b100100 : 6'b100000, "halt_run");
        for (int k = 0; k < 4; k++) cyc(6'b000000, "halt_drain");
        check("halt_done", {40'd0, o_done}, 41'd1);
`ifndef CYCLE_LIMIT_EN
        check("halt_count", {9'd0, o_cycle_count}, {9'd0, 32'd14});
`endif
        cyc(6'b001000, "halt_clear");
        check("clear_count", {o_state, 6'd0, o_cycle_count}, 41'd0);

        // Three single steps with idle gaps
        for (int k = 0; k < 3; k++) begin
            cyc(6'b010000, "step_pulse");
            cyc(6'b000000, "step_exec");
            cyc(6'b000000, "step_gap");
        end
        check("step_count", {o_state, 6'd0, o_cycle_count}, {3'd0, 6'd0, 32'd3});

        // RUN with no halt: cycle limit behaviour
        do_reset();
        cyc(6'b100000, "limit_idle");
        for (int k = 0; k < 12; k++) cyc(6'b100000, "limit_run");
`ifdef CYCLE_LIMIT_EN
        check("limit_end", {o_state, o_done, o_timeout, o_cycle_count}, {3'd4, 1'b1, 1'b1, 32'd12});
        cyc(6'b001000, "limit_clear");
        check("limit_cleared", {o_state, o_done, o_timeout, o_cycle_count}, 37'd0);
`else
        check("nolimit_end", {o_state, o_done, o_timeout, o_cycle_count}, {3'd1, 1'b0, 1'b0, 32'd12});
        cyc(6'b000000, "nolimit_pause");
        check("nolimit_paused", {o_state, o_done, o_timeout, o_cycle_count}, {3'd0, 1'b0, 1'b0, 32'd13});
`endif

        // Random traffic against the reference model
        for (int k = 0; k < 3000; k++) begin
            logic [5:0] in;
            in[5] = ($urandom % 4) != 0;
            in[4] = ($urandom % 4) == 0;
            in[3] = ($urandom % 6) == 0;
            in[2] = ($urandom % 16) == 0;
            in[1] = ($urandom % 4) == 0;
            in[0] = ($urandom % 4) == 0;
            cyc(in, "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
